// File: rtl/device_arbiter_rr_pkg.sv
// Shared types and sizing helpers for the bank-decoded device arbiter.
package device_arbiter_rr_pkg;

    // Index width that never collapses to zero bits, even for a single entry.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Occupancy counter width for a power-of-two FIFO of the given depth.
    function automatic int unsigned pending_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned DEFAULT_CONTROLLERS     = 4;
    localparam int unsigned DEFAULT_ACK_FIFO_LENGTH = 8;
    localparam int unsigned TAG_WIDTH               = clog2_min1(DEFAULT_CONTROLLERS);
    localparam int unsigned PENDING_WIDTH           = pending_width(DEFAULT_ACK_FIFO_LENGTH);

endpackage

// File: rtl/device_arbiter_tag_fifo.sv
// Synchronous FIFO of controller tags; pointers carry an extra wrap bit.
module device_arbiter_tag_fifo
    import device_arbiter_rr_pkg::*;
#(
    parameter int unsigned WIDTH = TAG_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_ACK_FIFO_LENGTH
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int unsigned PW = $clog2(DEPTH) + 1;
    localparam int unsigned AW = PW - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= i_push_data;
    end

    assign o_head  = mem[rd_ptr[AW-1:0]];
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_count = wr_ptr - rd_ptr;

endmodule

// File: rtl/device_arbiter_rr.sv
// Arbitrates N bank-qualified controllers onto one device; acks return in order via a tag FIFO.
module device_arbiter_rr
    import device_arbiter_rr_pkg::*;
#(
    parameter int unsigned NUM_CONTROLLERS = 4,
    parameter int unsigned ADDRESS_WIDTH   = 26,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BANK_WIDTH      = 4,
    parameter int unsigned DEVICE_BANK     = 0,
    parameter int unsigned ACK_FIFO_LENGTH = 8,
    parameter int unsigned ROUND_ROBIN     = 1,
    parameter int unsigned WRITE_ACK       = 0
) (
    input  logic                                    i_clk,
    input  logic                                    i_reset,
    input  logic [NUM_CONTROLLERS-1:0]              i_request,
    input  logic [NUM_CONTROLLERS-1:0]              i_write,
    input  logic [NUM_CONTROLLERS*BANK_WIDTH-1:0]   i_bank,
    input  logic [NUM_CONTROLLERS*ADDRESS_WIDTH-1:0] i_address,
    input  logic [NUM_CONTROLLERS*DATA_WIDTH-1:0]   i_data,
    output logic [NUM_CONTROLLERS-1:0]              o_busy,
    output logic [NUM_CONTROLLERS-1:0]              o_ack,
    output logic [NUM_CONTROLLERS*DATA_WIDTH-1:0]   o_data,
    output logic                                    o_device_request,
    output logic                                    o_device_write,
    output logic [ADDRESS_WIDTH-1:0]                o_device_address,
    output logic [DATA_WIDTH-1:0]                   o_device_data,
    input  logic                                    i_device_busy,
    input  logic                                    i_device_ack,
    input  logic [DATA_WIDTH-1:0]                   i_device_data,
    output logic [$clog2(ACK_FIFO_LENGTH):0]        o_pending,
    output logic                                    o_ack_underflow
);
    localparam int unsigned N  = NUM_CONTROLLERS;
    localparam int unsigned IW = clog2_min1(NUM_CONTROLLERS);

    logic [N-1:0]  qual;
    logic          any_q;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant_idx;
    logic [N-1:0]  grant_onehot;
    logic          needs_tag;
    logic          accept;
    logic          fifo_full;
    logic          fifo_empty;
    logic [IW-1:0] fifo_head;
    logic          pop;
    int unsigned   gsel;

    always_comb begin
        qual = '0;
        for (int unsigned i = 0; i < N; i++) begin
            qual[i] = i_request[i] && (i_bank[i*BANK_WIDTH +: BANK_WIDTH] == BANK_WIDTH'(DEVICE_BANK));
        end
    end

    assign any_q = |qual;

    // Search starts at rr_ptr in rotating mode, at index 0 in fixed mode.
    always_comb begin
        int unsigned base;
        int unsigned idx;
        logic        found;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        base      = (ROUND_ROBIN != 0) ? 32'(rr_ptr) : 32'd0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (base + k) % N;
            if (!found && qual[idx]) begin
                found     = 1'b1;
                grant_idx = IW'(idx);
            end
        end
    end

    assign gsel         = 32'(grant_idx);
    assign grant_onehot = any_q ? (N'(1) << grant_idx) : '0;
    assign needs_tag    = !i_write[gsel] || (WRITE_ACK != 0);
    assign accept       = any_q && !i_device_busy && !(needs_tag && fifo_full);
    assign o_busy       = qual & ~(accept ? grant_onehot : '0);

    assign o_device_request = any_q;
    assign o_device_write   = any_q && i_write[gsel];
    assign o_device_address = any_q ? i_address[gsel*ADDRESS_WIDTH +: ADDRESS_WIDTH] : '0;
    assign o_device_data    = any_q ? i_data[gsel*DATA_WIDTH +: DATA_WIDTH] : '0;

    // Pointer only advances on accept, so a blocked grant stays put.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (gsel == N - 1) ? '0 : grant_idx + IW'(1);
        end
    end

    assign pop = i_device_ack && !fifo_empty;

    device_arbiter_tag_fifo #(
        .WIDTH (IW),
        .DEPTH (ACK_FIFO_LENGTH)
    ) u_tag_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (accept && needs_tag),
        .i_push_data (grant_idx),
        .i_pop       (pop),
        .o_head      (fifo_head),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_count     (o_pending)
    );

    always_comb begin
        o_ack = '0;
        if (pop) o_ack[fifo_head] = 1'b1;
    end

    assign o_data = pop ? {N{i_device_data}} : '0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_ack_underflow <= 1'b0;
        end else begin
            o_ack_underflow <= i_device_ack && fifo_empty;
        end
    end

endmodule

// File: tb/tb_device_arbiter_rr.sv
// Scoreboard bench for device_arbiter_rr: directed stimulus queues expected grants/acks, a monitor checks them.
module tb_device_arbiter_rr;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 26;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;

    typedef struct {
        int          idx;
        logic [25:0] addr;
        logic        wr;
    } grant_t;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } ack_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    request = '0;
    logic [N-1:0]    write = '0;
    logic [N*BW-1:0] bank = '0;
    logic [N*AW-1:0] address = '0;
    logic [N*DW-1:0] wdata = '0;
    logic            dev_busy = 1'b0;
    logic            dev_ack = 1'b0;
    logic [DW-1:0]   dev_rdata = '0;

    logic [N-1:0]    busy, ack;
    logic [N*DW-1:0] rdata;
    logic            dev_req, dev_wr;
    logic [AW-1:0]   dev_addr;
    logic [DW-1:0]   dev_wdata;
    logic [3:0]      pending;
    logic            underflow;

    logic [N-1:0]    fp_busy, fp_ack;
    logic [N*DW-1:0] fp_rdata;
    logic            fp_dev_req, fp_dev_wr;
    logic [AW-1:0]   fp_dev_addr;
    logic [DW-1:0]   fp_dev_wdata;
    logic [3:0]      fp_pending;
    logic            fp_underflow;

    grant_t gq[$];
    ack_t   aq[$];
    int     pass_cnt = 0;
    int     total_cnt = 0;

    always #5 clk = ~clk;

    device_arbiter_rr #(.ROUND_ROBIN(1)) dut (
        .i_clk(clk), .i_reset(rst), .i_request(request), .i_write(write), .i_bank(bank),
        .i_address(address), .i_data(wdata), .o_busy(busy), .o_ack(ack), .o_data(rdata),
        .o_device_request(dev_req), .o_device_write(dev_wr), .o_device_address(dev_addr),
        .o_device_data(dev_wdata), .i_device_busy(dev_busy), .i_device_ack(dev_ack),
        .i_device_data(dev_rdata), .o_pending(pending), .o_ack_underflow(underflow)
    );

    device_arbiter_rr #(.ROUND_ROBIN(0)) dut_fp (
        .i_clk(clk), .i_reset(rst), .i_request(request), .i_write(write), .i_bank(bank),
        .i_address(address), .i_data(wdata), .o_busy(fp_busy), .o_ack(fp_ack), .o_data(fp_rdata),
        .o_device_request(fp_dev_req), .o_device_write(fp_dev_wr), .o_device_address(fp_dev_addr),
        .o_device_data(fp_dev_wdata), .i_device_busy(dev_busy), .i_device_ack(dev_ack),
        .i_device_data(dev_rdata), .o_pending(fp_pending), .o_ack_underflow(fp_underflow)
    );

    function automatic logic [AW-1:0] addr_of(input int i);
        return AW'(32'h1000 + i * 16);
    endfunction

    function automatic logic [N-1:0] qual_of(input logic [N-1:0] req, input logic [N*BW-1:0] bk);
        logic [N-1:0] q;
        for (int i = 0; i < N; i++) q[i] = req[i] && (bk[i*BW +: BW] == '0);
        return q;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        request  = '0;
        write    = '0;
        bank     = '0;
        dev_ack  = 1'b0;
        dev_busy = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Monitor: every accepted grant and every routed ack must match the queue head.
    always @(negedge clk) begin
        logic [N-1:0] acc;
        grant_t g;
        ack_t   a;
        if (!rst) begin
            acc = qual_of(request, bank) & ~busy;
            if (acc != '0) begin
                if (gq.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_grant: got %0h expected none at %0t", acc, $time);
                end else begin
                    g = gq.pop_front();
                    chk("grant", 64'(acc), 64'(N'(1) << g.idx));
                    chk("grant_addr", 64'(dev_addr), 64'(g.addr));
                    chk("grant_write", 64'(dev_wr), 64'(g.wr));
                end
            end
            if (ack != '0) begin
                if (aq.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_ack: got %0h expected none at %0t", ack, $time);
                end else begin
                    a = aq.pop_front();
                    chk("ack", 64'(ack), 64'(N'(1) << a.idx));
                    chk("ack_data", 64'(rdata[a.idx*DW +: DW]), 64'(a.data));
                end
            end
        end
    end

    initial begin
        logic [3:0] peak;
        for (int i = 0; i < N; i++) begin
            address[i*AW +: AW] = addr_of(i);
            wdata[i*DW +: DW]   = DW'(32'hD0 + i);
        end

        // Reset state
        do_reset();
        #3;
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_underflow", 64'(underflow), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_dev_req", 64'(dev_req), 64'd0);
        chk("rst_dev_addr", 64'(dev_addr), 64'd0);

        // Round robin over four readers, acks two cycles behind
        do_reset();
        for (int k = 0; k < 5; k++) begin
            gq.push_back('{idx: k % 4, addr: addr_of(k % 4), wr: 1'b0});
            aq.push_back('{idx: k % 4, data: 32'hA000 + 32'(k)});
        end
        peak = '0;
        for (int c = 0; c < 7; c++) begin
            request   = (c < 5) ? 4'hF : 4'h0;
            dev_ack   = (c >= 2);
            dev_rdata = 32'hA000 + 32'(c - 2);
            #3;
            if (pending > peak) peak = pending;
            step();
        end
        idle();
        #3;
        chk("rr_pending_peak", 64'(peak), 64'd2);
        chk("rr_pending_end", 64'(pending), 64'd0);

        // Fixed priority: 1 always wins over 3
        do_reset();
        request = 4'b1010;
        gq.push_back('{idx: 1, addr: addr_of(1), wr: 1'b0});
        gq.push_back('{idx: 3, addr: addr_of(3), wr: 1'b0});
        gq.push_back('{idx: 1, addr: addr_of(1), wr: 1'b0});
        gq.push_back('{idx: 3, addr: addr_of(3), wr: 1'b0});
        for (int c = 0; c < 4; c++) begin
            #3;
            chk("fp_busy", 64'(fp_busy), 64'(4'b1000));
            chk("fp_addr", 64'(fp_dev_addr), 64'(addr_of(1)));
            step();
        end
        idle();

        // Full FIFO: reads blocked, untagged writes pass, ack+read same cycle
        do_reset();
        for (int c = 0; c < 8; c++) begin
            request = 4'b0001;
            gq.push_back('{idx: 0, addr: addr_of(0), wr: 1'b0});
            step();
        end
        request = 4'b0001;
        #3;
        chk("full_pending", 64'(pending), 64'd8);
        chk("full_read_busy", 64'(busy), 64'(4'b0001));
        chk("full_dev_req", 64'(dev_req), 64'd1);
        step();
        request = 4'b0010;
        write   = 4'b0010;
        gq.push_back('{idx: 1, addr: addr_of(1), wr: 1'b1});
        #3;
        chk("full_write_ok", 64'(busy), 64'd0);
        step();
        request   = 4'b0001;
        write     = 4'b0000;
        dev_ack   = 1'b1;
        dev_rdata = 32'hB000;
        aq.push_back('{idx: 0, data: 32'hB000});
        #3;
        chk("full_ack_read_busy", 64'(busy), 64'(4'b0001));
        step();
        dev_ack = 1'b0;
        gq.push_back('{idx: 0, addr: addr_of(0), wr: 1'b0});
        #3;
        chk("full_read_next", 64'(busy), 64'd0);
        step();
        idle();
        #3;
        chk("full_pending_after", 64'(pending), 64'd8);
        for (int k = 0; k < 8; k++) begin
            dev_ack   = 1'b1;
            dev_rdata = 32'hB001 + 32'(k);
            aq.push_back('{idx: 0, data: 32'hB001 + 32'(k)});
            step();
        end
        idle();
        #3;
        chk("drain_pending", 64'(pending), 64'd0);

        // Wrong bank is ignored
        do_reset();
        request       = 4'b0100;
        bank[8 +: 4]  = 4'd5;
        #3;
        chk("bank_busy", 64'(busy), 64'd0);
        chk("bank_dev_req", 64'(dev_req), 64'd0);
        step();
        #3;
        chk("bank_pending", 64'(pending), 64'd0);
        idle();

        // Stray ack: single-cycle underflow pulse
        do_reset();
        dev_ack = 1'b1;
        #3;
        chk("stray_ack", 64'(ack), 64'd0);
        step();
        dev_ack = 1'b0;
        #3;
        chk("stray_underflow_hi", 64'(underflow), 64'd1);
        step();
        #3;
        chk("stray_underflow_lo", 64'(underflow), 64'd0);

        // Reset drops outstanding tags; later acks underflow
        do_reset();
        for (int c = 0; c < 3; c++) begin
            request = 4'b0001;
            gq.push_back('{idx: 0, addr: addr_of(0), wr: 1'b0});
            step();
        end
        idle();
        #3;
        chk("mid_pending", 64'(pending), 64'd3);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #3;
        chk("mid_rst_pending", 64'(pending), 64'd0);
        for (int k = 0; k < 3; k++) begin
            dev_ack = 1'b1;
            #3;
            chk("mid_ack", 64'(ack), 64'd0);
            if (k > 0) chk("mid_underflow", 64'(underflow), 64'd1);
            step();
        end
        dev_ack = 1'b0;
        #3;
        chk("mid_underflow_last", 64'(underflow), 64'd1);
        step();
        #3;
        chk("mid_underflow_lo", 64'(underflow), 64'd0);

        step();
        step();
        chk("grants_left", 64'(gq.size()), 64'd0);
        chk("acks_left", 64'(aq.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
